// File: rtl/tl_client_a_arbiter.sv
// Two-client TileLink-UL arbiter: round-robin on A with burst locking, D routed back by source MSB.
// Latency: zero; A grant and D routing are combinational, only arbitration state is registered.
// Backpressure: manager a_ready reaches only the granted client, and the locked client's gaps stall the bus.
module tl_client_a_arbiter #(
    parameter int SRC_W   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int LG_BEAT = 3
) (
    input  logic                clock,
    input  logic                reset,
    // client 0
    input  logic                auto_in_0_a_valid,
    output logic                auto_in_0_a_ready,
    input  logic [2:0]          auto_in_0_a_bits_opcode,
    input  logic [2:0]          auto_in_0_a_bits_param,
    input  logic [2:0]          auto_in_0_a_bits_size,
    input  logic [SRC_W-1:0]    auto_in_0_a_bits_source,
    input  logic [ADDR_W-1:0]   auto_in_0_a_bits_address,
    input  logic [DATA_W/8-1:0] auto_in_0_a_bits_mask,
    input  logic [DATA_W-1:0]   auto_in_0_a_bits_data,
    input  logic                auto_in_0_a_bits_corrupt,
    output logic                auto_in_0_d_valid,
    input  logic                auto_in_0_d_ready,
    output logic [2:0]          auto_in_0_d_bits_opcode,
    output logic [1:0]          auto_in_0_d_bits_param,
    output logic [2:0]          auto_in_0_d_bits_size,
    output logic [SRC_W-1:0]    auto_in_0_d_bits_source,
    output logic                auto_in_0_d_bits_sink,
    output logic                auto_in_0_d_bits_denied,
    output logic [DATA_W-1:0]   auto_in_0_d_bits_data,
    output logic                auto_in_0_d_bits_corrupt,
    // client 1
    input  logic                auto_in_1_a_valid,
    output logic                auto_in_1_a_ready,
    input  logic [2:0]          auto_in_1_a_bits_opcode,
    input  logic [2:0]          auto_in_1_a_bits_param,
    input  logic [2:0]          auto_in_1_a_bits_size,
    input  logic [SRC_W-1:0]    auto_in_1_a_bits_source,
    input  logic [ADDR_W-1:0]   auto_in_1_a_bits_address,
    input  logic [DATA_W/8-1:0] auto_in_1_a_bits_mask,
    input  logic [DATA_W-1:0]   auto_in_1_a_bits_data,
    input  logic                auto_in_1_a_bits_corrupt,
    output logic                auto_in_1_d_valid,
    input  logic                auto_in_1_d_ready,
    output logic [2:0]          auto_in_1_d_bits_opcode,
    output logic [1:0]          auto_in_1_d_bits_param,
    output logic [2:0]          auto_in_1_d_bits_size,
    output logic [SRC_W-1:0]    auto_in_1_d_bits_source,
    output logic                auto_in_1_d_bits_sink,
    output logic                auto_in_1_d_bits_denied,
    output logic [DATA_W-1:0]   auto_in_1_d_bits_data,
    output logic                auto_in_1_d_bits_corrupt,
    // manager
    output logic                auto_out_a_valid,
    input  logic                auto_out_a_ready,
    output logic [2:0]          auto_out_a_bits_opcode,
    output logic [2:0]          auto_out_a_bits_param,
    output logic [2:0]          auto_out_a_bits_size,
    output logic [SRC_W:0]      auto_out_a_bits_source,
    output logic [ADDR_W-1:0]   auto_out_a_bits_address,
    output logic [DATA_W/8-1:0] auto_out_a_bits_mask,
    output logic [DATA_W-1:0]   auto_out_a_bits_data,
    output logic                auto_out_a_bits_corrupt,
    input  logic                auto_out_d_valid,
    output logic                auto_out_d_ready,
    input  logic [2:0]          auto_out_d_bits_opcode,
    input  logic [1:0]          auto_out_d_bits_param,
    input  logic [2:0]          auto_out_d_bits_size,
    input  logic [SRC_W:0]      auto_out_d_bits_source,
    input  logic                auto_out_d_bits_sink,
    input  logic                auto_out_d_bits_denied,
    input  logic [DATA_W-1:0]   auto_out_d_bits_data,
    input  logic                auto_out_d_bits_corrupt
);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    localparam logic [2:0] LG_SZ = 3'(LG_BEAT);

    state_t     state_q, state_d;
    logic       lock_port_q, lock_port_d;
    logic [3:0] beats_left_q, beats_left_d;
    logic       last_grant_q, last_grant_d;

    logic       grant;
    logic       sel_valid;
    logic [2:0] sel_opcode;
    logic [2:0] sel_size;
    logic [3:0] sel_beats_m1;
    logic       a_fire;
    logic       d_port;

    // Grant: locked port during a burst, otherwise round-robin between valid clients
    always_comb begin
        grant = 1'b0;
        if (state_q == S_LOCKED)
            grant = lock_port_q;
        else if (auto_in_0_a_valid && auto_in_1_a_valid)
            grant = ~last_grant_q;
        else if (auto_in_1_a_valid)
            grant = 1'b1;
        else
            grant = 1'b0;
    end

    assign sel_valid  = grant ? auto_in_1_a_valid       : auto_in_0_a_valid;
    assign sel_opcode = grant ? auto_in_1_a_bits_opcode : auto_in_0_a_bits_opcode;
    assign sel_size   = grant ? auto_in_1_a_bits_size   : auto_in_0_a_bits_size;

    // Burst length minus one of the selected request; only data-carrying opcodes span beats
    always_comb begin
        sel_beats_m1 = 4'd0;
        if (sel_opcode <= 3'd3 && sel_size > LG_SZ)
            sel_beats_m1 = 4'((5'd1 << (sel_size - LG_SZ)) - 5'd1);
    end

    // Outputs are held quiet while reset is asserted
    assign auto_out_a_valid  = ~reset & sel_valid;
    assign auto_in_0_a_ready = ~reset & auto_out_a_ready & ~grant;
    assign auto_in_1_a_ready = ~reset & auto_out_a_ready &  grant;
    assign a_fire            = auto_out_a_valid & auto_out_a_ready;

    assign auto_out_a_bits_opcode  = sel_opcode;
    assign auto_out_a_bits_size    = sel_size;
    assign auto_out_a_bits_param   = grant ? auto_in_1_a_bits_param   : auto_in_0_a_bits_param;
    assign auto_out_a_bits_source  = {grant, (grant ? auto_in_1_a_bits_source : auto_in_0_a_bits_source)};
    assign auto_out_a_bits_address = grant ? auto_in_1_a_bits_address : auto_in_0_a_bits_address;
    assign auto_out_a_bits_mask    = grant ? auto_in_1_a_bits_mask    : auto_in_0_a_bits_mask;
    assign auto_out_a_bits_data    = grant ? auto_in_1_a_bits_data    : auto_in_0_a_bits_data;
    assign auto_out_a_bits_corrupt = grant ? auto_in_1_a_bits_corrupt : auto_in_0_a_bits_corrupt;

    // Next-state: lock on the first beat of a multi-beat burst, count down the remaining beats
    always_comb begin
        state_d      = state_q;
        lock_port_d  = lock_port_q;
        beats_left_d = beats_left_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (a_fire) begin
                    last_grant_d = grant;
                    if (sel_beats_m1 != 4'd0) begin
                        state_d      = S_LOCKED;
                        lock_port_d  = grant;
                        beats_left_d = sel_beats_m1;
                    end
                end
            end
            S_LOCKED: begin
                if (a_fire) begin
                    if (beats_left_q == 4'd1) begin
                        state_d      = S_IDLE;
                        beats_left_d = 4'd0;
                    end else begin
                        beats_left_d = beats_left_q - 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Arbitration state register; last_grant resets to 1 so port 0 wins first contention
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lock_port_q  <= 1'b0;
            beats_left_q <= 4'd0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            lock_port_q  <= lock_port_d;
            beats_left_q <= beats_left_d;
            last_grant_q <= last_grant_d;
        end
    end

    // D routing is stateless: the source MSB names the client, the rest is broadcast
    assign d_port            = auto_out_d_bits_source[SRC_W];
    assign auto_in_0_d_valid = ~reset & auto_out_d_valid & ~d_port;
    assign auto_in_1_d_valid = ~reset & auto_out_d_valid &  d_port;
    assign auto_out_d_ready  = ~reset & (d_port ? auto_in_1_d_ready : auto_in_0_d_ready);

    assign auto_in_0_d_bits_opcode  = auto_out_d_bits_opcode;
    assign auto_in_0_d_bits_param   = auto_out_d_bits_param;
    assign auto_in_0_d_bits_size    = auto_out_d_bits_size;
    assign auto_in_0_d_bits_source  = auto_out_d_bits_source[SRC_W-1:0];
    assign auto_in_0_d_bits_sink    = auto_out_d_bits_sink;
    assign auto_in_0_d_bits_denied  = auto_out_d_bits_denied;
    assign auto_in_0_d_bits_data    = auto_out_d_bits_data;
    assign auto_in_0_d_bits_corrupt = auto_out_d_bits_corrupt;

    assign auto_in_1_d_bits_opcode  = auto_out_d_bits_opcode;
    assign auto_in_1_d_bits_param   = auto_out_d_bits_param;
    assign auto_in_1_d_bits_size    = auto_out_d_bits_size;
    assign auto_in_1_d_bits_source  = auto_out_d_bits_source[SRC_W-1:0];
    assign auto_in_1_d_bits_sink    = auto_out_d_bits_sink;
    assign auto_in_1_d_bits_denied  = auto_out_d_bits_denied;
    assign auto_in_1_d_bits_data    = auto_out_d_bits_data;
    assign auto_in_1_d_bits_corrupt = auto_out_d_bits_corrupt;

endmodule

// File: tb/tb_tl_client_a_arbiter.sv
// Bench for the two-client A arbiter and D router.
// Expected A beats are queued as stimulus is driven and popped on each manager-side fire.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_tl_client_a_arbiter;

    typedef struct packed {
        logic [4:0]  src;
        logic [31:0] addr;
        logic [63:0] data;
    } sb_t;

    logic        clk;
    logic        reset;
    logic        a_v    [2];
    logic [2:0]  a_op   [2];
    logic [2:0]  a_sz   [2];
    logic [3:0]  a_src  [2];
    logic [31:0] a_addr [2];
    logic [63:0] a_data [2];
    logic        a_rdy  [2];
    logic        d_v    [2];
    logic        d_rdy  [2];
    logic [2:0]  d_op   [2];
    logic [1:0]  d_par  [2];
    logic [2:0]  d_sz   [2];
    logic [3:0]  d_src  [2];
    logic        d_sink [2];
    logic        d_den  [2];
    logic [63:0] d_dat  [2];
    logic        d_cor  [2];

    logic        o_a_valid, o_a_ready;
    logic [2:0]  o_a_opcode, o_a_param, o_a_size;
    logic [4:0]  o_a_source;
    logic [31:0] o_a_address;
    logic [7:0]  o_a_mask;
    logic [63:0] o_a_data;
    logic        o_a_corrupt;
    logic        o_d_valid, o_d_ready;
    logic [4:0]  o_d_source;
    logic [63:0] o_d_data;

    int  checks = 0;
    int  failures = 0;
    sb_t sb_q[$];

    tl_client_a_arbiter dut (
        .clock(clk), .reset(reset),
        .auto_in_0_a_valid(a_v[0]), .auto_in_0_a_ready(a_rdy[0]),
        .auto_in_0_a_bits_opcode(a_op[0]), .auto_in_0_a_bits_param(3'd0),
        .auto_in_0_a_bits_size(a_sz[0]), .auto_in_0_a_bits_source(a_src[0]),
        .auto_in_0_a_bits_address(a_addr[0]), .auto_in_0_a_bits_mask(8'hFF),
        .auto_in_0_a_bits_data(a_data[0]), .auto_in_0_a_bits_corrupt(1'b0),
        .auto_in_0_d_valid(d_v[0]), .auto_in_0_d_ready(d_rdy[0]),
        .auto_in_0_d_bits_opcode(d_op[0]), .auto_in_0_d_bits_param(d_par[0]),
        .auto_in_0_d_bits_size(d_sz[0]), .auto_in_0_d_bits_source(d_src[0]),
        .auto_in_0_d_bits_sink(d_sink[0]), .auto_in_0_d_bits_denied(d_den[0]),
        .auto_in_0_d_bits_data(d_dat[0]), .auto_in_0_d_bits_corrupt(d_cor[0]),
        .auto_in_1_a_valid(a_v[1]), .auto_in_1_a_ready(a_rdy[1]),
        .auto_in_1_a_bits_opcode(a_op[1]), .auto_in_1_a_bits_param(3'd0),
        .auto_in_1_a_bits_size(a_sz[1]), .auto_in_1_a_bits_source(a_src[1]),
        .auto_in_1_a_bits_address(a_addr[1]), .auto_in_1_a_bits_mask(8'hFF),
        .auto_in_1_a_bits_data(a_data[1]), .auto_in_1_a_bits_corrupt(1'b0),
        .auto_in_1_d_valid(d_v[1]), .auto_in_1_d_ready(d_rdy[1]),
        .auto_in_1_d_bits_opcode(d_op[1]), .auto_in_1_d_bits_param(d_par[1]),
        .auto_in_1_d_bits_size(d_sz[1]), .auto_in_1_d_bits_source(d_src[1]),
        .auto_in_1_d_bits_sink(d_sink[1]), .auto_in_1_d_bits_denied(d_den[1]),
        .auto_in_1_d_bits_data(d_dat[1]), .auto_in_1_d_bits_corrupt(d_cor[1]),
        .auto_out_a_valid(o_a_valid), .auto_out_a_ready(o_a_ready),
        .auto_out_a_bits_opcode(o_a_opcode), .auto_out_a_bits_param(o_a_param),
        .auto_out_a_bits_size(o_a_size), .auto_out_a_bits_source(o_a_source),
        .auto_out_a_bits_address(o_a_address), .auto_out_a_bits_mask(o_a_mask),
        .auto_out_a_bits_data(o_a_data), .auto_out_a_bits_corrupt(o_a_corrupt),
        .auto_out_d_valid(o_d_valid), .auto_out_d_ready(o_d_ready),
        .auto_out_d_bits_opcode(3'd1), .auto_out_d_bits_param(2'd0),
        .auto_out_d_bits_size(3'd3), .auto_out_d_bits_source(o_d_source),
        .auto_out_d_bits_sink(1'b0), .auto_out_d_bits_denied(1'b0),
        .auto_out_d_bits_data(o_d_data), .auto_out_d_bits_corrupt(1'b0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Fixed per-client identity: source 2 / 0x1000_0000 for client 0, source 5 / 0x2000_0000 for client 1
    task automatic drive(input int p, input logic v, input logic [2:0] op, input logic [2:0] sz,
                         input logic [63:0] data);
        a_v[p]    = v;
        a_op[p]   = op;
        a_sz[p]   = sz;
        a_src[p]  = (p == 0) ? 4'h2 : 4'h5;
        a_addr[p] = (p == 0) ? 32'h1000_0000 : 32'h2000_0000;
        a_data[p] = data;
    endtask

    task automatic expect_beat(input int p, input logic [63:0] data);
        sb_t e;
        e.src  = (p == 0) ? 5'h02 : 5'h15;
        e.addr = (p == 0) ? 32'h1000_0000 : 32'h2000_0000;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Pop the scoreboard on a manager-side fire, then move to the next cycle
    task automatic adv();
        sb_t e;
        if (o_a_valid && o_a_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_fire got src=%h addr=%h required no beat", o_a_source, o_a_address);
            end else begin
                e = sb_q.pop_front();
                if (o_a_source !== e.src || o_a_address !== e.addr || o_a_data !== e.data) begin
                    failures++;
                    $display("FAIL sb_beat got src=%h addr=%h data=%h required src=%h addr=%h data=%h",
                             o_a_source, o_a_address, o_a_data, e.src, e.addr, e.data);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 1'b1, 3'd4, 3'd3, 64'h0);
        drive(1, 1'b1, 3'd4, 3'd3, 64'h0);
        o_a_ready = 1'b1;
        o_d_valid = 1'b1; o_d_source = 5'h13; o_d_data = 64'h0;
        d_rdy[0] = 1'b1; d_rdy[1] = 1'b1;
        #2;
        checks++;
        if ({o_a_valid, a_rdy[0], a_rdy[1], d_v[0], d_v[1], o_d_ready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got %b required 000000",
                     {o_a_valid, a_rdy[0], a_rdy[1], d_v[0], d_v[1], o_d_ready});
        end
        a_v[0] = 1'b0; a_v[1] = 1'b0; o_d_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++) expect_beat(i % 2, 64'hB000 + 64'(i % 2));
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 3'd4, 3'd3, 64'hB000);
            drive(1, 1'b1, 3'd4, 3'd3, 64'hB001);
            #1;
            checks++;
            if (a_rdy[0] !== (i % 2 == 0) || o_a_source[4] !== 1'(i % 2)) begin
                failures++;
                $display("FAIL rr_grant cycle=%0d got rdy0=%b srcmsb=%b required rdy0=%b srcmsb=%0d",
                         i, a_rdy[0], o_a_source[4], (i % 2 == 0), i % 2);
            end
            adv();
        end
        a_v[0] = 1'b0; a_v[1] = 1'b0;
    endtask

    task automatic test_burst_lock();
        for (int k = 0; k < 8; k++) expect_beat(0, 64'hA000 + 64'(k));
        expect_beat(1, 64'hB001);
        drive(1, 1'b1, 3'd4, 3'd3, 64'hB001);
        for (int k = 0; k < 9; k++) begin
            if (k < 8) drive(0, 1'b1, 3'd0, 3'd6, 64'hA000 + 64'(k));
            else a_v[0] = 1'b0;
            #1;
            checks++;
            if (a_rdy[1] !== (k == 8) || a_rdy[0] !== (k < 8)) begin
                failures++;
                $display("FAIL burst_lock cycle=%0d got rdy0=%b rdy1=%b required rdy0=%b rdy1=%b",
                         k, a_rdy[0], a_rdy[1], (k < 8), (k == 8));
            end
            adv();
        end
        a_v[1] = 1'b0;
    endtask

    task automatic test_valid_gap();
        int beat;
        for (int k = 0; k < 8; k++) expect_beat(0, 64'hC000 + 64'(k));
        expect_beat(1, 64'hB001);
        drive(1, 1'b1, 3'd4, 3'd3, 64'hB001);
        beat = 0;
        for (int c = 0; c < 12; c++) begin
            if (c >= 3 && c < 6) a_v[0] = 1'b0;
            else if (beat < 8) drive(0, 1'b1, 3'd0, 3'd6, 64'hC000 + 64'(beat));
            else a_v[0] = 1'b0;
            #1;
            if (c >= 3 && c < 6) begin
                checks++;
                if (o_a_valid !== 1'b0 || a_rdy[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL gap_hold cycle=%0d got out_valid=%b rdy1=%b required 0 0",
                             c, o_a_valid, a_rdy[1]);
                end
            end
            if (a_v[0] && a_rdy[0]) beat++;
            adv();
        end
        checks++;
        if (beat !== 8) begin
            failures++;
            $display("FAIL gap_burst_done got beats=%0d required 8", beat);
        end
        a_v[1] = 1'b0;
    endtask

    task automatic test_stall();
        expect_beat(0, 64'hB000);
        expect_beat(1, 64'hB001);
        drive(0, 1'b1, 3'd4, 3'd3, 64'hB000);
        drive(1, 1'b1, 3'd4, 3'd3, 64'hB001);
        o_a_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (o_a_valid !== 1'b1 || o_a_source !== 5'h02 || o_a_address !== 32'h1000_0000 ||
                a_rdy[0] !== 1'b0 || a_rdy[1] !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d got valid=%b src=%h addr=%h rdy=%b%b required 1 02 10000000 00",
                         c, o_a_valid, o_a_source, o_a_address, a_rdy[0], a_rdy[1]);
            end
            adv();
        end
        o_a_ready = 1'b1;
        #1;
        adv();
        #1;
        checks++;
        if (o_a_source !== 5'h15) begin
            failures++;
            $display("FAIL stall_next_grant got src=%h required 15", o_a_source);
        end
        adv();
        a_v[0] = 1'b0; a_v[1] = 1'b0;
    endtask

    task automatic test_d_route();
        o_d_valid = 1'b1; o_d_source = 5'h13; o_d_data = 64'hDEAD_BEEF_0123_4567;
        d_rdy[0] = 1'b1; d_rdy[1] = 1'b0;
        #1;
        checks++;
        if (d_v[1] !== 1'b1 || d_src[1] !== 4'h3 || d_v[0] !== 1'b0 || o_d_ready !== 1'b0 ||
            d_dat[0] !== 64'hDEAD_BEEF_0123_4567) begin
            failures++;
            $display("FAIL d_route_p1 got v1=%b src1=%h v0=%b rdy=%b dat0=%h required 1 3 0 0 deadbeef01234567",
                     d_v[1], d_src[1], d_v[0], o_d_ready, d_dat[0]);
        end
        d_rdy[1] = 1'b1;
        #1;
        checks++;
        if (o_d_ready !== 1'b1) begin
            failures++;
            $display("FAIL d_ready_p1 got %b required 1", o_d_ready);
        end
        o_d_source = 5'h04; d_rdy[0] = 1'b0;
        #1;
        checks++;
        if (d_v[0] !== 1'b1 || d_v[1] !== 1'b0 || d_src[0] !== 4'h4 || o_d_ready !== 1'b0) begin
            failures++;
            $display("FAIL d_route_p0 got v0=%b v1=%b src0=%h rdy=%b required 1 0 4 0",
                     d_v[0], d_v[1], d_src[0], o_d_ready);
        end
        o_d_valid = 1'b0; d_rdy[0] = 1'b1;
        adv();
    endtask

    task automatic test_reset_mid_burst();
        expect_beat(0, 64'hE000);
        expect_beat(0, 64'hE001);
        drive(1, 1'b1, 3'd4, 3'd3, 64'hB001);
        for (int k = 0; k < 2; k++) begin
            drive(0, 1'b1, 3'd0, 3'd6, 64'hE000 + 64'(k));
            #1;
            adv();
        end
        drive(0, 1'b1, 3'd0, 3'd6, 64'hE002);
        o_d_valid = 1'b1; o_d_source = 5'h13;
        reset = 1'b1;
        #1;
        checks++;
        if ({o_a_valid, a_rdy[0], a_rdy[1], d_v[0], d_v[1], o_d_ready} !== 6'b0) begin
            failures++;
            $display("FAIL midburst_reset_outputs got %b required 000000",
                     {o_a_valid, a_rdy[0], a_rdy[1], d_v[0], d_v[1], o_d_ready});
        end
        o_d_valid = 1'b0;
        adv();
        reset = 1'b0;
        expect_beat(0, 64'hB000);
        expect_beat(1, 64'hB001);
        for (int c = 0; c < 2; c++) begin
            drive(0, 1'b1, 3'd4, 3'd3, 64'hB000);
            drive(1, 1'b1, 3'd4, 3'd3, 64'hB001);
            #1;
            checks++;
            if (a_rdy[0] !== (c == 0) || a_rdy[1] !== (c == 1)) begin
                failures++;
                $display("FAIL post_reset_grant cycle=%0d got rdy0=%b rdy1=%b required %b %b",
                         c, a_rdy[0], a_rdy[1], (c == 0), (c == 1));
            end
            adv();
        end
        a_v[0] = 1'b0; a_v[1] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_valid_gap();
        test_stall();
        test_d_route();
        test_reset_mid_burst();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d beats outstanding required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tl_client_a_arbiter.md
Name: tl_client_a_arbiter

Overview:
- Merges two TileLink-UL client ports onto one manager port, using round-robin arbitration on channel A with beat-accurate burst locking.
- Routes channel D responses back to the originating client by a source-ID bit the arbiter prepends.
- Sits between per-client probe/monitor nodes and the shared bus port.
- The arbiter owns sequencing of the shared A channel.

Parameters:
SRC_W, 4, client source ID width
ADDR_W, 32, address width
DATA_W, 64, data width; beat bytes = DATA_W/8
LG_BEAT, 3, log2(DATA_W/8)

Ports:
clock  input  1  single clock
reset  input  1  asynchronous, active-high reset
auto_in_{0,1}_a_valid  input  1  client A valid
auto_in_{0,1}_a_ready  output  1  client A ready
auto_in_{0,1}_a_bits_opcode/param/size  input  3 each  A header
auto_in_{0,1}_a_bits_source  input  SRC_W  A source
auto_in_{0,1}_a_bits_address  input  ADDR_W  A address
auto_in_{0,1}_a_bits_mask  input  DATA_W/8  A mask
auto_in_{0,1}_a_bits_data  input  DATA_W  A data
auto_in_{0,1}_a_bits_corrupt  input  1  A corrupt
auto_in_{0,1}_d_valid  output  1  client D valid
auto_in_{0,1}_d_ready  input  1  client D ready
auto_in_{0,1}_d_bits_*  output  as out D (source SRC_W)  D payload
auto_out_a_valid / auto_out_a_ready  output / input  1  manager A handshake
auto_out_a_bits_*  output  as client A (source SRC_W+1)  muxed A payload
auto_out_d_valid / auto_out_d_ready  input / output  1  manager D handshake
auto_out_d_bits_opcode/size  input  3  D header
auto_out_d_bits_param  input  2  D param
auto_out_d_bits_source  input  SRC_W+1  D source
auto_out_d_bits_sink/denied/corrupt  input  1  D flags
auto_out_d_bits_data  input  DATA_W  D data

Behaviour:
- State: IDLE / LOCKED; regs: lock_port (1b), beats_left (4b), last_grant (1b).
- Reset values (asynchronous):
  - State IDLE, beats_left 0, lock_port 0, last_grant 1, so port 0 wins the first contention.
  - While reset is asserted, auto_out_a_valid, both a_ready, both d_valid and auto_out_d_ready are 0.
- Beat count for an A request:
  - Applies to opcodes 0..3 (PutFull, PutPartial, Arithmetic, Logical).
  - beats = (size <= LG_BEAT) ? 1 : 1 << (size - LG_BEAT). Max 16 at DATA_W=64.
  - Opcodes 4 (Get) and 5 (Intent) are 1 beat.
- IDLE grant is combinational, with zero added latency:
  - If only one client is valid, that client is granted.
  - If both are valid, the client != last_grant is granted.
  - auto_out_a_valid = valid of the granted client.
  - auto_in_x_a_ready = auto_out_a_ready & (grant == x).
  - The ungranted ready is 0.
- Fire of the first beat with beats > 1:
  - Go to LOCKED.
  - lock_port <= grant, beats_left <= beats - 1, last_grant <= grant.
- Fire of a single-beat request: last_grant <= grant; stay IDLE.
- LOCKED:
  - The mux is forced to lock_port regardless of the other client's valid.
  - Each fire decrements beats_left; fire with beats_left == 1 returns to IDLE.
  - A valid drop by the locked client mid-burst holds LOCKED; auto_out_a_valid goes 0 and the other client stays blocked.
- A payload:
  - All fields pass through unmodified from the granted client.
  - auto_out_a_bits_source = {grant, client source}.
- D routing is purely combinational and needs no lock:
  - port = auto_out_d_bits_source[SRC_W].
  - auto_in_x_d_valid = auto_out_d_valid & (port == x).
  - auto_out_d_ready = auto_in_port_d_ready.
  - Client D source = auto_out_d_bits_source[SRC_W-1:0]; other D fields are broadcast to both clients.
- A and D are independent; simultaneous A fire and D fire in one cycle are both legal.
- Reset mid-burst: return immediately to IDLE with beats_left = 0. The partial burst is not resumed.
- A valid/ready never depend combinationally on D signals.

Test Plan:
- Both clients issue Get (opcode 4, size 3) every cycle, out a_ready = 1:
  - Grants alternate 0,1,0,1.
  - out source MSB alternates, starting with 0 after reset.
- Client 0 PutFull (size 6, 8 beats), client 1 Get valid throughout:
  - 8 consecutive port-0 beats, then client 1 granted on cycle 9.
  - auto_in_1_a_ready = 0 for cycles 1..8.
- Locked port 0 with beats_left = 5, drop in_0 valid for 3 cycles while in_1 is valid:
  - out a_valid = 0 and in_1 a_ready = 0 during the gap.
  - The burst completes after in_0 resumes.
- out a_ready held 0 for 4 cycles during contention:
  - Grant stays fixed (last_grant unchanged) and the payload is stable until fire.
- D response with source 5'h13 and client 1 d_ready = 0:
  - auto_in_1_d_valid = 1 with source 4'h3, auto_in_0_d_valid = 0, auto_out_d_ready = 0.
- Assert reset on beat 3 of an 8-beat burst:
  - Outputs are 0 during reset.
  - After release, state is IDLE and port 0 wins contention.
